// File: rtl/wb_stage.sv
// Write-back stage: picks the register-file write value, formats loads,
// and keeps a one-cycle WB->ID bypass register plus a retired-instruction count.
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  mem_to_reg,
    input  logic                  jump_link,
    input  logic [XLEN-1:0]       pc_plus4,
    input  logic [1:0]            load_size,
    input  logic                  load_unsigned,
    input  logic [1:0]            byte_off,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       write_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic                  byp_valid,
    output logic [REG_ADDR_W-1:0] byp_rd,
    output logic [XLEN-1:0]       byp_data,
    output logic [CNT_W-1:0]      instret
);

    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_fmt;

    always_comb begin
        load_byte = 8'h00;
        case (byte_off)
            2'd0:    load_byte = mem_data[7:0];
            2'd1:    load_byte = mem_data[15:8];
            2'd2:    load_byte = mem_data[23:16];
            default: load_byte = mem_data[31:24];
        endcase
        // halfword lane only depends on the upper offset bit
        load_half = byte_off[1] ? mem_data[31:16] : mem_data[15:0];
    end

    always_comb begin
        load_fmt = mem_data;
        case (load_size)
            2'b01:   load_fmt = {{(XLEN-8){~load_unsigned & load_byte[7]}}, load_byte};
            2'b10:   load_fmt = {{(XLEN-16){~load_unsigned & load_half[15]}}, load_half};
            default: load_fmt = mem_data;
        endcase
    end

    always_comb begin
        if (jump_link)
            write_data = pc_plus4;
        else if (mem_to_reg)
            write_data = load_fmt;
        else
            write_data = alu_result;
    end

    assign rf_we    = wb_valid & reg_write & (rd != '0);
    assign rf_waddr = rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_valid <= 1'b0;
            byp_rd    <= '0;
            byp_data  <= '0;
        end else begin
            byp_valid <= rf_we;
            byp_rd    <= rd;
            byp_data  <= write_data;
        end
    end

    // counts every live instruction, including x0 and non-writing ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= '0;
        else if (wb_valid)
            instret <= instret + 1'b1;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected values are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_wb_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int CW   = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wb_valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mem_data;
    logic            mem_to_reg;
    logic            jump_link;
    logic [XLEN-1:0] pc_plus4;
    logic [1:0]      load_size;
    logic            load_unsigned;
    logic [1:0]      byte_off;
    logic            reg_write;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] write_data;
    logic            rf_we;
    logic [RW-1:0]   rf_waddr;
    logic            byp_valid;
    logic [RW-1:0]   byp_rd;
    logic [XLEN-1:0] byp_data;
    logic [CW-1:0]   instret;

    int applied    = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];
    logic [CW-1:0] exp_cnt;

    wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .alu_result(alu_result),
        .mem_data(mem_data), .mem_to_reg(mem_to_reg), .jump_link(jump_link),
        .pc_plus4(pc_plus4), .load_size(load_size), .load_unsigned(load_unsigned),
        .byte_off(byte_off), .reg_write(reg_write), .rd(rd),
        .write_data(write_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
        .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        applied++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; wb_valid = 1'b0; alu_result = '0; mem_data = '0;
        mem_to_reg = 1'b0; jump_link = 1'b0; pc_plus4 = '0; load_size = 2'b00;
        load_unsigned = 1'b0; byte_off = 2'd0; reg_write = 1'b0; rd = '0;
        exp_cnt = '0;

        #3;
        push(64'h0); check("rst_byp_valid", {63'h0, byp_valid});
        push(64'h0); check("rst_byp_data", {32'h0, byp_data});
        push(64'h0); check("rst_instret", instret);

        @(negedge clk);
        rst_n = 1'b1;
        alu_result = 32'hA5A5A5A5; mem_data = 32'hDEADBEEF;
        #1;
        push(64'hA5A5A5A5); check("sel_alu", {32'h0, write_data});

        mem_to_reg = 1'b1; #1;
        push(64'hDEADBEEF); check("sel_mem_word", {32'h0, write_data});

        load_size = 2'b01; byte_off = 2'd3; load_unsigned = 1'b0; #1;
        push(64'hFFFFFFDE); check("byte3_signed", {32'h0, write_data});
        load_unsigned = 1'b1; #1;
        push(64'h000000DE); check("byte3_unsigned", {32'h0, write_data});
        byte_off = 2'd0; #1;
        push(64'h000000EF); check("byte0_unsigned", {32'h0, write_data});
        byte_off = 2'd1; load_unsigned = 1'b0; #1;
        push(64'hFFFFFFBE); check("byte1_signed", {32'h0, write_data});

        load_size = 2'b10; byte_off = 2'd2; load_unsigned = 1'b0; #1;
        push(64'hFFFFDEAD); check("half2_signed", {32'h0, write_data});
        byte_off = 2'd3; #1;
        push(64'hFFFFDEAD); check("half3_off0_ignored", {32'h0, write_data});
        byte_off = 2'd0; load_unsigned = 1'b1; #1;
        push(64'h0000BEEF); check("half0_unsigned", {32'h0, write_data});

        load_size = 2'b11; #1;
        push(64'hDEADBEEF); check("reserved_as_word", {32'h0, write_data});

        jump_link = 1'b1; pc_plus4 = 32'h00000104; #1;
        push(64'h00000104); check("sel_link", {32'h0, write_data});

        // x0 write: suppressed enable, still retires
        @(negedge clk);
        wb_valid = 1'b1; reg_write = 1'b1; rd = 5'd0; #1;
        push(64'h0); check("x0_rf_we", {63'h0, rf_we});
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 1;
        push(64'h0); check("x0_byp_valid", {63'h0, byp_valid});
        push(64'h00000104); check("x0_byp_data", {32'h0, byp_data});
        push(exp_cnt); check("x0_instret", instret);

        @(negedge clk);
        jump_link = 1'b0; mem_to_reg = 1'b0; alu_result = 32'h12345678; rd = 5'd5; #1;
        push(64'h1); check("rd5_rf_we", {63'h0, rf_we});
        push(64'h5); check("rd5_rf_waddr", {59'h0, rf_waddr});
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 1;
        push(64'h1); check("rd5_byp_valid", {63'h0, byp_valid});
        push(64'h5); check("rd5_byp_rd", {59'h0, byp_rd});
        push(64'h12345678); check("rd5_byp_data", {32'h0, byp_data});
        push(exp_cnt); check("rd5_instret", instret);

        // bubble: bypass drops after one cycle, counter holds
        @(negedge clk);
        wb_valid = 1'b0;
        @(posedge clk); #1;
        push(64'h0); check("bubble_byp_valid", {63'h0, byp_valid});
        push(exp_cnt); check("bubble_instret", instret);

        // asynchronous reset between edges
        @(negedge clk);
        rst_n = 1'b0; #1;
        exp_cnt = '0;
        push(64'h0); check("async_byp_valid", {63'h0, byp_valid});
        push(64'h0); check("async_byp_data", {32'h0, byp_data});
        push(exp_cnt); check("async_instret", instret);
        push(64'h12345678); check("rst_comb_write_data", {32'h0, write_data});

        @(negedge clk);
        rst_n = 1'b1; wb_valid = 1'b1; reg_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            exp_cnt = exp_cnt + 1;
        end
        #1;
        push(exp_cnt); check("ten_instret", instret);
        push(64'h0); check("nowrite_byp_valid", {63'h0, byp_valid});

        @(negedge clk);
        wb_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
